// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: MDUOp encodings, default latencies,
// counter width and small decode helpers.
package mdu_ctrl_pkg;

  localparam int CNT_W           = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_launch_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E/D-stage interface of the multiply/divide unit. E_cancel exists only when
// MDU_CANCEL_EN is defined.
interface mdu_ctrl_if;
  logic        E_start;
  logic [3:0]  E_MDUOp;
  logic [31:0] E_rs_val;
  logic [31:0] E_rt_val;
  logic        D_md_use;
  logic        busy;
  logic        stall_md;
  logic [31:0] E_mdu_out;
`ifdef MDU_CANCEL_EN
  logic        E_cancel;

  modport master (output E_start, E_MDUOp, E_rs_val, E_rt_val, D_md_use, E_cancel,
                  input  busy, stall_md, E_mdu_out);
  modport slave  (input  E_start, E_MDUOp, E_rs_val, E_rt_val, D_md_use, E_cancel,
                  output busy, stall_md, E_mdu_out);
`else
  modport master (output E_start, E_MDUOp, E_rs_val, E_rt_val, D_md_use,
                  input  busy, stall_md, E_mdu_out);
  modport slave  (input  E_start, E_MDUOp, E_rs_val, E_rt_val, D_md_use,
                  output busy, stall_md, E_mdu_out);
`endif
endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational multiply/divide datapath producing the values later committed to HI/LO.
module mdu_ctrl_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] pend_hi,
  output logic [31:0] pend_lo,
  output logic        div_by_zero
);

  logic signed [63:0] rs_sx_s, rt_sx_s, prod_s_s;
  logic [63:0]        prod_u_s;
  logic [31:0]        rs_mag_s, rt_mag_s, divisor_u_s, divisor_m_s;
  logic [31:0]        quot_u_s, rem_u_s, quot_m_s, rem_m_s;

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps back to 0x80000000.
  always_comb begin
    rs_sx_s     = {{32{rs[31]}}, rs};
    rt_sx_s     = {{32{rt[31]}}, rt};
    prod_s_s    = rs_sx_s * rt_sx_s;
    prod_u_s    = {32'd0, rs} * {32'd0, rt};
    rs_mag_s    = rs[31] ? (32'd0 - rs) : rs;
    rt_mag_s    = rt[31] ? (32'd0 - rt) : rt;
    divisor_u_s = (rt == 32'd0) ? 32'd1 : rt;
    divisor_m_s = (rt == 32'd0) ? 32'd1 : rt_mag_s;
    quot_u_s    = rs / divisor_u_s;
    rem_u_s     = rs % divisor_u_s;
    quot_m_s    = rs_mag_s / divisor_m_s;
    rem_m_s     = rs_mag_s % divisor_m_s;
  end

  // Result selection per operation.
  always_comb begin
    pend_hi     = 32'd0;
    pend_lo     = 32'd0;
    div_by_zero = 1'b0;
    case (op)
      MDU_MULT:  {pend_hi, pend_lo} = prod_s_s;
      MDU_MULTU: {pend_hi, pend_lo} = prod_u_s;
      MDU_DIV: begin
        pend_lo     = (rs[31] ^ rt[31]) ? (32'd0 - quot_m_s) : quot_m_s;
        pend_hi     = rs[31] ? (32'd0 - rem_m_s) : rem_m_s;
        div_by_zero = (rt == 32'd0);
      end
      MDU_DIVU: begin
        pend_lo     = quot_u_s;
        pend_hi     = rem_u_s;
        div_by_zero = (rt == 32'd0);
      end
      default: begin
        pend_hi     = 32'd0;
        pend_lo     = 32'd0;
        div_by_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: busy counter, pending result, HI/LO, stall and mf output mux.
// Optional E-stage cancel is built when MDU_CANCEL_EN is defined.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave md
);

  logic [CNT_W-1:0] cnt_r, cnt_n_s;
  logic [31:0]      hi_r, hi_n_s, lo_r, lo_n_s;
  logic [31:0]      pend_hi_r, pend_hi_n_s, pend_lo_r, pend_lo_n_s;
  logic             pend_dbz_r, pend_dbz_n_s;
  logic             busy_r;
  logic [31:0]      arith_hi_s, arith_lo_s;
  logic             arith_dbz_s;
  logic             cancel_s;
  mdu_state_e       state_s;

`ifdef MDU_CANCEL_EN
  assign cancel_s = md.E_cancel;
`else
  assign cancel_s = 1'b0;
`endif

  mdu_ctrl_arith u_arith (
    .op          (md.E_MDUOp),
    .rs          (md.E_rs_val),
    .rt          (md.E_rt_val),
    .pend_hi     (arith_hi_s),
    .pend_lo     (arith_lo_s),
    .div_by_zero (arith_dbz_s)
  );

  assign state_s = (cnt_r != CNT_W'(0)) ? ST_BUSY : ST_IDLE;

  // Next-state: launch or mt in IDLE, countdown and commit in BUSY.
  always_comb begin
    cnt_n_s      = cnt_r;
    hi_n_s       = hi_r;
    lo_n_s       = lo_r;
    pend_hi_n_s  = pend_hi_r;
    pend_lo_n_s  = pend_lo_r;
    pend_dbz_n_s = pend_dbz_r;
    case (state_s)
      ST_IDLE: begin
        if (cancel_s) begin
          cnt_n_s = CNT_W'(0);
        end else if (md.E_start && is_launch_op(md.E_MDUOp)) begin
          cnt_n_s      = is_mult_op(md.E_MDUOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          pend_hi_n_s  = arith_hi_s;
          pend_lo_n_s  = arith_lo_s;
          pend_dbz_n_s = arith_dbz_s;
        end else if (!md.E_start && (md.E_MDUOp == MDU_MTHI)) begin
          hi_n_s = md.E_rs_val;
        end else if (!md.E_start && (md.E_MDUOp == MDU_MTLO)) begin
          lo_n_s = md.E_rs_val;
        end else begin
          cnt_n_s = CNT_W'(0);
        end
      end
      ST_BUSY: begin
        if (cancel_s) begin
          cnt_n_s      = CNT_W'(0);
          pend_hi_n_s  = 32'd0;
          pend_lo_n_s  = 32'd0;
          pend_dbz_n_s = 1'b0;
        end else if ((cnt_r == CNT_W'(1)) && !pend_dbz_r) begin
          cnt_n_s = CNT_W'(0);
          hi_n_s  = pend_hi_r;
          lo_n_s  = pend_lo_r;
        end else begin
          cnt_n_s = cnt_r - CNT_W'(1);
        end
      end
      default: cnt_n_s = CNT_W'(0);
    endcase
  end

  // State register with synchronous reset that also drops any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r      <= CNT_W'(0);
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      pend_hi_r  <= 32'd0;
      pend_lo_r  <= 32'd0;
      pend_dbz_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      cnt_r      <= cnt_n_s;
      hi_r       <= hi_n_s;
      lo_r       <= lo_n_s;
      pend_hi_r  <= pend_hi_n_s;
      pend_lo_r  <= pend_lo_n_s;
      pend_dbz_r <= pend_dbz_n_s;
      busy_r     <= (cnt_n_s != CNT_W'(0));
    end
  end

  assign md.busy     = busy_r;
  assign md.stall_md = md.D_md_use & (md.E_start | busy_r);

  // mfhi/mflo read the architectural registers directly.
  always_comb begin
    case (md.E_MDUOp)
      MDU_MFHI: md.E_mdu_out = hi_r;
      MDU_MFLO: md.E_mdu_out = lo_r;
      default:  md.E_mdu_out = 32'd0;
    endcase
  end

endmodule
